// File: rtl/rr_chan_arbiter_pkg.sv
// Shared helpers for the round-robin channel arbiter.
// Width derivation lives here so select and counter widths agree across files.
package rr_chan_arbiter_pkg;

    // ceil(log2(n)) clamped to at least 1 so select/counter vectors never collapse to zero width.
    function automatic int ceil_log2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_chan_arbiter_rr_pick.sv
// Rotating priority encoder: first requester at or after ptr_i, wrapping modulo NCH.
// Purely combinational; any_o low when no request is present.
module rr_chan_arbiter_rr_pick #(
    parameter int NCH  = 4,
    parameter int NSEL = 2
) (
    input  logic [NCH-1:0]  req_i,
    input  logic [NSEL-1:0] ptr_i,
    output logic [NSEL-1:0] idx_o,
    output logic            any_o
);

    always_comb begin
        int c;
        c     = 0;
        idx_o = '0;
        any_o = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            c = int'(ptr_i) + i;
            if (c >= NCH) c = c - NCH;
            if (!any_o && req_i[c]) begin
                any_o = 1'b1;
                idx_o = NSEL'(c);
            end
        end
    end

endmodule

// File: rtl/rr_chan_arbiter.sv
// Round-robin burst arbiter: one granted channel streams words to a shared valid/ready port.
// Grant latency 1 cycle, at least one idle cycle between bursts. ARB_TIMEOUT_EN adds a stall release.
module rr_chan_arbiter
    import rr_chan_arbiter_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int NCH     = 4,
    parameter int TIMEOUT = 255,
    localparam int NSEL   = ceil_log2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       req,
    input  logic [NCH-1:0]       last,
    input  logic [NCH*WIDTH-1:0] in,
    output logic [NCH-1:0]       ack,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic [NSEL-1:0]      out_sel,
    output logic                 busy,
    output logic                 err
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [NSEL-1:0] ptr_q, ptr_d;
    logic [NSEL-1:0] sel_q, sel_d;
    logic [NSEL-1:0] pick_idx;
    logic            pick_any;
    logic [NSEL-1:0] ptr_wrap;
    logic            xfer;
    logic            fire;
    logic            timeout_hit;

    if (NCH < 2 || TIMEOUT < 1) begin : g_cfg_check
        $error("rr_chan_arbiter: NCH must be >= 2 and TIMEOUT >= 1");
    end

    rr_chan_arbiter_rr_pick #(
        .NCH  (NCH),
        .NSEL (NSEL)
    ) u_pick (
        .req_i (req),
        .ptr_i (ptr_q),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // A dropped request mid-burst only gates valid; the grant itself is never revoked.
    assign xfer      = (state_q == ST_XFER);
    assign out_valid = xfer & req[sel_q];
    assign out_data  = in[sel_q*WIDTH +: WIDTH];
    assign out_last  = last[sel_q] & out_valid;
    assign fire      = out_valid & out_ready;
    assign busy      = xfer;
    assign out_sel   = sel_q;
    assign ptr_wrap  = (sel_q == NSEL'(NCH - 1)) ? '0 : sel_q + 1'b1;

    always_comb begin
        ack = '0;
        if (fire) ack[sel_q] = 1'b1;
    end

`ifdef ARB_TIMEOUT_EN
    localparam int STALL_W = ceil_log2(TIMEOUT + 1);

    logic [STALL_W-1:0] stall_q, stall_d;

    // Fires on the TIMEOUT-th consecutive cycle without an accepted word.
    assign timeout_hit = xfer & ~fire & (stall_q == STALL_W'(TIMEOUT - 1));
    assign err         = timeout_hit;

    always_comb begin
        stall_d = stall_q;
        if (!xfer || fire || timeout_hit) stall_d = '0;
        else                              stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_q <= '0;
        else     stall_q <= stall_d;
    end
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    sel_d   = pick_idx;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if ((fire && last[sel_q]) || timeout_hit) begin
                    state_d = ST_IDLE;
                    ptr_d   = ptr_wrap;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
        end
    end

endmodule

// File: tb/tb_rr_chan_arbiter.sv
// Directed bench for rr_chan_arbiter: per-channel burst sources, hand-computed expectations.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_rr_chan_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  last;
    logic [63:0] in_bus;
    logic [3:0]  ack;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_last;
    logic        out_ready;
    logic [1:0]  out_sel;
    logic        busy;
    logic        err;

    rr_chan_arbiter #(
        .WIDTH   (16),
        .NCH     (4),
        .TIMEOUT (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .last      (last),
        .in        (in_bus),
        .ack       (ack),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .out_sel   (out_sel),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // Source model: each channel sends s_nbr bursts of s_len words; word = {ch, burst, idx}.
    int   s_len [4];
    int   s_nbr [4];
    int   s_idx [4];
    int   s_brst[4];
    logic s_drop[4];

    logic [3:0]  smp_ack;
    logic        smp_vld;
    logic [15:0] smp_dat;
    logic        smp_last;
    logic [1:0]  smp_sel;
    logic        smp_busy;
    logic        smp_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic drive();
        for (int c = 0; c < 4; c++) begin
            logic active;
            active = (s_brst[c] < s_nbr[c]);
            req[c] = active && !s_drop[c];
            last[c] = active && (s_idx[c] == s_len[c] - 1);
            in_bus[c*16 +: 16] = {4'(c), 4'(s_brst[c]), 8'(s_idx[c])};
        end
    endtask

    task automatic load(input int c, input int len, input int nbr);
        s_len[c]  = len;
        s_nbr[c]  = nbr;
        s_idx[c]  = 0;
        s_brst[c] = 0;
        s_drop[c] = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
        smp_ack  = ack;
        smp_vld  = out_valid;
        smp_dat  = out_data;
        smp_last = out_last;
        smp_sel  = out_sel;
        smp_busy = busy;
        smp_err  = err;
        @(posedge clk);
        #1;
        for (int c = 0; c < 4; c++) begin
            if (smp_ack[c]) begin
                s_idx[c]++;
                if (s_idx[c] == s_len[c]) begin
                    s_idx[c] = 0;
                    s_brst[c]++;
                end
            end
        end
        drive();
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [1:0]  grant_q[$];
    int          start_q[$];
    logic [20:0] word_q[$];
    logic        prev_busy;

    initial begin
        rst       = 1'b1;
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) load(c, 1, 0);
        drive();

        // 1: reset values, then ten idle cycles with no requests
        @(negedge clk);
        chk("rst_outputs", {busy, out_valid, ack, out_last, out_sel, err}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_quiet", {smp_busy, smp_vld, smp_ack}, 32'h0);
        end

        // 2: all four request, 3-word bursts; ch0 has a second burst
        load(0, 3, 2);
        for (int c = 1; c < 4; c++) load(c, 3, 1);
        out_ready = 1'b1;
        drive();
        prev_busy = 1'b0;
        for (int i = 0; i < 24; i++) begin
            step();
            if (smp_busy && !prev_busy) begin
                grant_q.push_back(smp_sel);
                start_q.push_back(cyc);
            end
            if (smp_ack != 4'b0) word_q.push_back({smp_ack, smp_last, smp_dat});
            prev_busy = smp_busy;
        end
        begin
            logic [1:0] exp_order[5];
            exp_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
            chk("rr_grant_count", grant_q.size(), 5);
            chk("rr_word_count", word_q.size(), 15);
            for (int b = 0; b < 5; b++) begin
                chk("rr_grant_order", (b < grant_q.size()) ? grant_q[b] : 2'bxx, exp_order[b]);
                if (b < 4)
                    chk("rr_burst_spacing",
                        (b + 1 < start_q.size()) ? start_q[b+1] - start_q[b] : -1, 4);
                for (int k = 0; k < 3; k++) begin
                    logic [3:0]  ebit;
                    logic [15:0] edat;
                    int          w;
                    w    = b * 3 + k;
                    ebit = 4'b0001 << exp_order[b];
                    edat = {2'b00, exp_order[b], 4'((b == 4) ? 1 : 0), 8'(k)};
                    chk("rr_word", (w < word_q.size()) ? word_q[w] : 21'h1fffff,
                        {ebit, (k == 2), edat});
                end
            end
        end
        chk("rr_done_idle", smp_busy, 1'b0);

        // 3: ch2 alone, 4 words, ready toggling from the first transfer cycle
        load(2, 4, 1);
        out_ready = 1'b1;
        drive();
        step();
        chk("stall_grant_wait", smp_busy, 1'b0);
        for (int k = 0; k < 7; k++) begin
            out_ready = (k % 2 == 0);
            step();
            chk("stall_ack", smp_ack, (k % 2 == 0) ? 4'b0100 : 4'b0000);
            chk("stall_data", smp_dat, {8'h20, 8'((k + 1) / 2)});
            chk("stall_last", smp_last, (k >= 5));
        end
        out_ready = 1'b1;
        step();
        chk("stall_release", smp_busy, 1'b0);

        // 4: ch1 drops request for 5 cycles mid-burst while ch3 waits
        load(1, 3, 1);
        drive();
        step();
        load(3, 2, 1);
        drive();
        step();
        chk("drop_first_word", {smp_ack, smp_dat}, {4'b0010, 16'h1000});
        s_drop[1] = 1'b1;
        drive();
        for (int i = 0; i < 5; i++) begin
            step();
            chk("drop_hold", {smp_busy, smp_vld, smp_ack, smp_last, smp_sel}, {1'b1, 1'b0, 4'b0, 1'b0, 2'd1});
        end
        s_drop[1] = 1'b0;
        drive();
        step();
        chk("drop_resume_w1", {smp_ack, smp_last, smp_dat}, {4'b0010, 1'b0, 16'h1001});
        step();
        chk("drop_resume_w2", {smp_ack, smp_last, smp_dat}, {4'b0010, 1'b1, 16'h1002});
        step();
        chk("drop_gap", smp_busy, 1'b0);
        step();
        chk("drop_next_grant", {smp_busy, smp_sel, smp_ack}, {1'b1, 2'd3, 4'b1000});
        step();
        step();
        chk("drop_ch3_done", smp_busy, 1'b0);

        // single-word burst on ch0
        load(0, 1, 1);
        drive();
        step();
        step();
        chk("single_word", {smp_busy, smp_ack, smp_last, smp_sel, smp_dat}, {1'b1, 4'b0001, 1'b1, 2'd0, 16'h0000});
        step();
        chk("single_release", smp_busy, 1'b0);

        // 5: async reset mid-burst on ch0 (pointer is 1 beforehand)
        load(0, 4, 1);
        drive();
        step();
        step();
        chk("rst_pre_word", {smp_ack, smp_dat}, {4'b0001, 16'h0000});
        rst = 1'b1;
        #1;
        chk("rst_immediate", {busy, ack, out_valid, out_sel, err}, 32'h0);
        load(1, 2, 1);
        drive();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        step();
        chk("rst_gap", smp_busy, 1'b0);
        step();
        chk("rst_regrant_ch0", {smp_busy, smp_sel, smp_ack, smp_dat}, {1'b1, 2'd0, 4'b0001, 16'h0001});
        for (int i = 0; i < 8; i++) step();
        chk("rst_drain", {(s_brst[0] == 1), (s_brst[1] == 1), busy}, 3'b110);

`ifdef ARB_TIMEOUT_EN
        // 6: ch2 stalled with ready low; timeout releases on the 8th stall cycle
        load(2, 2, 1);
        out_ready = 1'b0;
        drive();
        step();
        chk("to_gap", smp_busy, 1'b0);
        for (int k = 0; k < 8; k++) begin
            step();
            chk("to_stall", {smp_busy, smp_vld, smp_ack, smp_sel}, {1'b1, 1'b1, 4'b0, 2'd2});
            chk("to_err", smp_err, (k == 7));
        end
        load(3, 1, 1);
        drive();
        step();
        chk("to_release", {smp_busy, smp_err}, 2'b00);
        step();
        chk("to_next_grant", {smp_busy, smp_sel}, {1'b1, 2'd3});
`else
        // 6: without the timeout a stalled grant is held and err never rises
        load(2, 2, 1);
        out_ready = 1'b0;
        drive();
        step();
        for (int k = 0; k < 12; k++) begin
            step();
            chk("hold_stall", {smp_busy, smp_vld, smp_err, smp_ack, smp_sel}, {1'b1, 1'b1, 1'b0, 4'b0, 2'd2});
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
